// File: rtl/consmax_pkg.sv
// Shared configuration and types for consmax and its output packer.
package consmax_pkg;

  localparam int ODATA_BIT  = 8;
  localparam int PACK_NUM   = 4;
  localparam int FIFO_DEPTH = 8;
  localparam int ROW_BIT    = 8;

  typedef struct packed {
    logic [ODATA_BIT*PACK_NUM-1:0] data;
    logic [PACK_NUM-1:0]           mask;
    logic                          last;
  } opack_word_t;

endpackage

// File: rtl/consmax_opack_fifo.sv
// Synchronous first-word-fall-through FIFO of packed words with occupancy count.
module consmax_opack_fifo
  import consmax_pkg::*;
#(
  parameter type word_t = opack_word_t,
  parameter int  DEPTH  = FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push,
  input  word_t                    push_word,
  input  logic                     pop_ready,
  output word_t                    head,
  output logic                     head_valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  word_t          mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           pop;
  logic           do_write;

  assign empty      = (count == '0);
  assign full       = (count == CNT_W'(DEPTH));
  assign head_valid = !empty;
  assign head       = empty ? '0 : mem[rd_ptr];

  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign pop      = head_valid && pop_ready;
  assign do_write = push && (!full || pop);

  // NOTE: the storage array has no reset; only pointers and count do, and an
  // empty FIFO masks the head to zero, so stale entries are never visible.
  always_ff @(posedge clk) begin
    if (do_write) mem[wr_ptr] <= push_word;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_write) wr_ptr <= wr_ptr + AW'(1);
      if (pop)      rd_ptr <= rd_ptr + AW'(1);
      case ({do_write, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/consmax_opack.sv
// Packs the consmax element stream into PACK_NUM-lane words, tags row ends,
// and buffers words for a valid/ready consumer with sticky overflow detection.
module consmax_opack #(
  parameter int ODATA_BIT  = consmax_pkg::ODATA_BIT,
  parameter int PACK_NUM   = consmax_pkg::PACK_NUM,
  parameter int FIFO_DEPTH = consmax_pkg::FIFO_DEPTH,
  parameter int ROW_BIT    = consmax_pkg::ROW_BIT
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic [ROW_BIT-1:0]              cfg_row_len,
  input  logic [ODATA_BIT-1:0]            idata,
  input  logic                            idata_valid,
  output logic [ODATA_BIT*PACK_NUM-1:0]   odata,
  output logic [PACK_NUM-1:0]             odata_mask,
  output logic                            odata_last,
  output logic                            odata_valid,
  input  logic                            odata_ready,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_cnt,
  output logic                            ovf_err,
  input  logic                            err_clr
);

  localparam int LANE_W = $clog2(PACK_NUM);
  localparam int LEN_W  = ROW_BIT + 1;

  typedef struct packed {
    logic [ODATA_BIT*PACK_NUM-1:0] data;
    logic [PACK_NUM-1:0]           mask;
    logic                          last;
  } word_t;

  logic [LANE_W-1:0]              lane_ptr;
  logic [ROW_BIT-1:0]             row_cnt;
  logic [LEN_W-1:0]               row_len_q;
  logic [LEN_W-1:0]               row_len_cur;
  logic [ODATA_BIT*PACK_NUM-1:0]  data_q;
  logic [ODATA_BIT*PACK_NUM-1:0]  data_next;
  logic [PACK_NUM-1:0]            mask_q;
  logic [PACK_NUM-1:0]            mask_next;
  logic                           row_end;
  logic                           word_done;
  word_t                          push_word;
  logic                           push_valid;
  word_t                          head;
  logic                           fifo_full;
  logic                           fifo_empty;
  logic                           drop;

  // NOTE: every always_comb output gets a default before any conditional
  // update, so no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    // A zero config encodes the full 2**ROW_BIT row length.
    row_len_cur = (row_cnt == '0) ? {cfg_row_len == '0, cfg_row_len} : row_len_q;
    row_end     = ({1'b0, row_cnt} == (row_len_cur - LEN_W'(1)));
    data_next   = data_q;
    mask_next   = mask_q;
    data_next[lane_ptr*ODATA_BIT +: ODATA_BIT] = idata;
    mask_next[lane_ptr] = 1'b1;
    word_done   = idata_valid && ((lane_ptr == LANE_W'(PACK_NUM-1)) || row_end);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lane_ptr   <= '0;
      row_cnt    <= '0;
      row_len_q  <= '0;
      data_q     <= '0;
      mask_q     <= '0;
      push_word  <= '0;
      push_valid <= 1'b0;
    end else begin
      push_valid <= word_done;
      if (idata_valid) begin
        if (row_cnt == '0) row_len_q <= row_len_cur;
        row_cnt <= row_end ? '0 : row_cnt + ROW_BIT'(1);
        if (word_done) begin
          lane_ptr  <= '0;
          data_q    <= '0;
          mask_q    <= '0;
          push_word <= '{data: data_next, mask: mask_next, last: row_end};
        end else begin
          lane_ptr <= lane_ptr + LANE_W'(1);
          data_q   <= data_next;
          mask_q   <= mask_next;
        end
      end
    end
  end

  consmax_opack_fifo #(
    .word_t (word_t),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rstn       (rstn),
    .push       (push_valid),
    .push_word  (push_word),
    .pop_ready  (odata_ready),
    .head       (head),
    .head_valid (odata_valid),
    .count      (fifo_cnt),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  assign odata      = head.data;
  assign odata_mask = head.mask;
  assign odata_last = head.last;

  // The FIFO itself ignores this push; here it only raises the sticky flag.
  assign drop = push_valid && fifo_full && !(odata_valid && odata_ready);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)        ovf_err <= 1'b0;
    else if (drop)    ovf_err <= 1'b1;
    else if (err_clr) ovf_err <= 1'b0;
  end

endmodule
